rf8x16_clken: RTL and testbench

- Eight-entry, 16-bit register file built around the 16-bit clock-enabled register stage.
- Decodes a single write port into one clock enable per entry, so only the addressed register loads; every other entry holds.
- Provides two combinational read ports and a per-entry written/valid scoreboard.
- Sits upstream of the datapath ALU operand muxes and downstream of the write-back stage.

---
 rtl/rf8x16_clken.sv | 111 +++++++++++
 tb/tb_rf8x16_clken.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rf8x16_clken.sv
// rf8x16_clken: 8-entry x 16-bit register file with one write port, two
// combinational read ports and a per-entry valid scoreboard.
// Each entry is a clock-enabled register; the write decode produces one enable
// per entry so only the addressed register loads.
// Optional feature macro: RF8X16_BYPASS_EN (same-cycle write-to-read forwarding).
module rf8x16_clken #(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 3,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic          clk_n_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          clr_i,
  input  logic [AW-1:0] rd_addr_a_i,
  output logic [DW-1:0] rd_data_a_o,
  output logic          rd_valid_a_o,
  input  logic [AW-1:0] rd_addr_b_i,
  output logic [DW-1:0] rd_data_b_o,
  output logic          rd_valid_b_o,
  output logic [AW:0]   wr_count_o
);

  localparam int unsigned Depth = 1 << AW;
  // Entry 0 is permanently valid when hard-wired to zero, so the count starts at 1.
  localparam logic [AW:0] CountBase = {{AW{1'b0}}, ZERO_R0};
  localparam logic [AW:0] CountMax  = (AW+1)'(Depth);

  logic [DW-1:0]    entry_q [Depth];
  logic [Depth-1:0] en;
  logic [Depth-1:0] valid_q, valid_d;
  logic [AW:0]      count_q, count_d;

  // Write decode: one clock enable per entry; writes to a hard-wired r0 are dropped.
  always_comb begin
    en = '0;
    for (int i = 0; i < Depth; i++) begin
      if (wr_en_i && (wr_addr_i == AW'(i))) en[i] = 1'b1;
    end
    if (ZERO_R0) en[0] = 1'b0;
  end

  // Per-entry clock-enabled data registers; clr leaves data untouched.
  for (genvar g = 0; g < Depth; g++) begin : g_entry
    always_ff @(posedge clk_n_i or posedge rst_i) begin
      if (rst_i) begin
        entry_q[g] <= '0;
      end else if (en[g]) begin
        entry_q[g] <= wr_data_i;
      end
    end
  end

  // Scoreboard next state: clr takes effect first, then the write on the same edge.
  always_comb begin
    valid_d = clr_i ? '0 : valid_q;
    valid_d = valid_d | en;
    count_d = clr_i ? CountBase : count_q;
    if ((|en) && (clr_i || !(|(en & valid_q))) && (count_d != CountMax)) begin
      count_d = count_d + 1'b1;
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge clk_n_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      count_q <= CountBase;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign wr_count_o = count_q;

  // Read port A: stored entry, optional forwarding, r0 override last.
  always_comb begin
    rd_data_a_o  = entry_q[rd_addr_a_i];
    rd_valid_a_o = valid_q[rd_addr_a_i];
`ifdef RF8X16_BYPASS_EN
    if (en[rd_addr_a_i]) begin
      rd_data_a_o  = wr_data_i;
      rd_valid_a_o = 1'b1;
    end
`endif
    if (ZERO_R0 && (rd_addr_a_i == '0)) begin
      rd_data_a_o  = '0;
      rd_valid_a_o = 1'b1;
    end
  end

  // Read port B: identical to port A, independent address.
  always_comb begin
    rd_data_b_o  = entry_q[rd_addr_b_i];
    rd_valid_b_o = valid_q[rd_addr_b_i];
`ifdef RF8X16_BYPASS_EN
    if (en[rd_addr_b_i]) begin
      rd_data_b_o  = wr_data_i;
      rd_valid_b_o = 1'b1;
    end
`endif
    if (ZERO_R0 && (rd_addr_b_i == '0)) begin
      rd_data_b_o  = '0;
      rd_valid_b_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_rf8x16_clken.sv
// Directed, table-driven bench for rf8x16_clken (default parameters, ZERO_R0=1).
module tb_rf8x16_clken;

  logic        clk_n;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        clr;
  logic [2:0]  rd_addr_a;
  logic [15:0] rd_data_a;
  logic        rd_valid_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_b;
  logic        rd_valid_b;
  logic [3:0]  wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  rf8x16_clken dut (
    .clk_n_i     (clk_n),
    .rst_i       (rst),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .clr_i       (clr),
    .rd_addr_a_i (rd_addr_a),
    .rd_data_a_o (rd_data_a),
    .rd_valid_a_o(rd_valid_a),
    .rd_addr_b_i (rd_addr_b),
    .rd_data_b_o (rd_data_b),
    .rd_valid_b_o(rd_valid_b),
    .wr_count_o  (wr_count)
  );

  initial clk_n = 1'b0;
  always #5 clk_n = ~clk_n;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        cl;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] eda;
    logic        eva;
    logic [15:0] edb;
    logic        evb;
    logic [3:0]  ecnt;
  } vec_t;

  localparam int NVec = 19;
  vec_t vec [NVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one vector across an edge, drop the write, then sample the reads.
  task automatic step(input vec_t v, input int idx);
    wr_en     = v.we;
    wr_addr   = v.wa;
    wr_data   = v.wd;
    clr       = v.cl;
    rd_addr_a = v.ra;
    rd_addr_b = v.rb;
    @(posedge clk_n);
    #1;
    wr_en = 1'b0;
    clr   = 1'b0;
    #1;
    check($sformatf("v%0d data_a", idx), {16'h0, rd_data_a}, {16'h0, v.eda});
    check($sformatf("v%0d valid_a", idx), {31'h0, rd_valid_a}, {31'h0, v.eva});
    check($sformatf("v%0d data_b", idx), {16'h0, rd_data_b}, {16'h0, v.edb});
    check($sformatf("v%0d valid_b", idx), {31'h0, rd_valid_b}, {31'h0, v.evb});
    check($sformatf("v%0d count", idx), {28'h0, wr_count}, {28'h0, v.ecnt});
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         we  wa    wd        cl  ra    rb    eda       eva  edb       evb  cnt
    vec[0]  = '{1, 3'd1, 16'h1111, 0, 3'd1, 3'd0, 16'h1111, 1, 16'h0000, 1, 4'd2};
    vec[1]  = '{1, 3'd2, 16'h2222, 0, 3'd2, 3'd1, 16'h2222, 1, 16'h1111, 1, 4'd3};
    vec[2]  = '{1, 3'd3, 16'h3333, 0, 3'd3, 3'd7, 16'h3333, 1, 16'h0000, 0, 4'd4};
    vec[3]  = '{1, 3'd4, 16'h4444, 0, 3'd4, 3'd2, 16'h4444, 1, 16'h2222, 1, 4'd5};
    vec[4]  = '{1, 3'd5, 16'h5555, 0, 3'd5, 3'd5, 16'h5555, 1, 16'h5555, 1, 4'd6};
    vec[5]  = '{1, 3'd6, 16'h6666, 0, 3'd6, 3'd4, 16'h6666, 1, 16'h4444, 1, 4'd7};
    vec[6]  = '{1, 3'd7, 16'h7777, 0, 3'd7, 3'd3, 16'h7777, 1, 16'h3333, 1, 4'd8};
    vec[7]  = '{1, 3'd7, 16'haaaa, 0, 3'd7, 3'd6, 16'haaaa, 1, 16'h6666, 1, 4'd8};
    vec[8]  = '{1, 3'd0, 16'hbeef, 0, 3'd0, 3'd1, 16'h0000, 1, 16'h1111, 1, 4'd8};
    vec[9]  = '{1, 3'd3, 16'hdddd, 0, 3'd3, 3'd3, 16'hdddd, 1, 16'hdddd, 1, 4'd8};
    vec[10] = '{0, 3'd3, 16'hffff, 0, 3'd3, 3'd2, 16'hdddd, 1, 16'h2222, 1, 4'd8};
    vec[11] = '{0, 3'd3, 16'hffff, 0, 3'd3, 3'd4, 16'hdddd, 1, 16'h4444, 1, 4'd8};
    vec[12] = '{0, 3'd3, 16'hffff, 0, 3'd3, 3'd5, 16'hdddd, 1, 16'h5555, 1, 4'd8};
    vec[13] = '{0, 3'd3, 16'hffff, 0, 3'd3, 3'd6, 16'hdddd, 1, 16'h6666, 1, 4'd8};
    vec[14] = '{1, 3'd5, 16'h4444, 0, 3'd5, 3'd5, 16'h4444, 1, 16'h4444, 1, 4'd8};
    vec[15] = '{1, 3'd6, 16'hcccc, 1, 3'd6, 3'd2, 16'hcccc, 1, 16'h2222, 0, 4'd2};
    vec[16] = '{0, 3'd0, 16'h0000, 0, 3'd0, 3'd1, 16'h0000, 1, 16'h1111, 0, 4'd2};
    vec[17] = '{1, 3'd2, 16'h9999, 0, 3'd2, 3'd6, 16'h9999, 1, 16'hcccc, 1, 4'd3};
    vec[18] = '{0, 3'd0, 16'h0000, 1, 3'd6, 3'd2, 16'hcccc, 0, 16'h9999, 0, 4'd1};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0;
    repeat (2) @(posedge clk_n);
    #2 rst = 1'b0;

    // Reset state across all addresses on both ports.
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(7 - a);
      #1;
      check($sformatf("rst data_a[%0d]", a), {16'h0, rd_data_a}, 32'h0);
      check($sformatf("rst valid_a[%0d]", a), {31'h0, rd_valid_a}, (a == 0) ? 32'h1 : 32'h0);
      check($sformatf("rst data_b[%0d]", 7 - a), {16'h0, rd_data_b}, 32'h0);
      check($sformatf("rst valid_b[%0d]", 7 - a), {31'h0, rd_valid_b},
            (a == 7) ? 32'h1 : 32'h0);
    end
    check("rst count", {28'h0, wr_count}, 32'h1);

    for (int i = 0; i < NVec; i++) step(vec[i], i);

    // Bypass: present a write to entry 2 and look before the edge.
    @(negedge clk_n);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h8888; rd_addr_a = 3'd2; rd_addr_b = 3'd0;
    #1;
`ifdef RF8X16_BYPASS_EN
    check("byp data_a", {16'h0, rd_data_a}, 32'h8888);
    check("byp valid_a", {31'h0, rd_valid_a}, 32'h1);
`else
    check("nobyp data_a", {16'h0, rd_data_a}, 32'h9999);
    check("nobyp valid_a", {31'h0, rd_valid_a}, 32'h0);
`endif
    check("byp r0 data_b", {16'h0, rd_data_b}, 32'h0);
    @(posedge clk_n);
    #1;
    wr_en = 1'b0;
    #1;
    check("post data_a", {16'h0, rd_data_a}, 32'h8888);
    check("post valid_a", {31'h0, rd_valid_a}, 32'h1);
    check("post count", {28'h0, wr_count}, 32'h2);

    // Async reset pulse mid-cycle, sampled before any further edge.
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #0.5;
    check("arst data_a", {16'h0, rd_data_a}, 32'h0);
    check("arst valid_a", {31'h0, rd_valid_a}, 32'h0);
    check("arst count", {28'h0, wr_count}, 32'h1);

    // Reset held through a write edge: nothing loads.
    @(negedge clk_n);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h1234; rd_addr_a = 3'd4;
    @(posedge clk_n);
    #1;
    wr_en = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("rstwr data_a", {16'h0, rd_data_a}, 32'h0);
    check("rstwr valid_a", {31'h0, rd_valid_a}, 32'h0);
    check("rstwr count", {28'h0, wr_count}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
